// File: rtl/dcls_lockstep_checker.sv
// rtl/dcls_lockstep_checker.sv - dual-core lockstep output comparator with sticky error capture
// Aligns the delayed main-core bus against the secondary bus and latches per-channel divergence.
module dcls_lockstep_checker #(
    parameter int NUM_CH     = 16,
    parameter int CH_W       = 32,
    parameter int DCLS_DELAY = 2,
    parameter int CNT_W      = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_CH*CH_W-1:0]   main_bus_i,
    input  logic [NUM_CH*CH_W-1:0]   sec_bus_i,
    input  logic [NUM_CH-1:0]        ch_mask_i,
    input  logic                     enable_i,
    input  logic                     clear_i,
    input  logic                     cnt_clr_i,
    output logic                     error_o,
    output logic [NUM_CH-1:0]        error_vector_o,
    output logic [NUM_CH-1:0]        first_vector_o,
    output logic                     irq_o,
    output logic [CNT_W-1:0]         err_count_o,
    output logic [1:0]               state_o
);

    localparam int BUS_W = NUM_CH * CH_W;
    localparam logic [3:0] ARM_LAST = 4'(DCLS_DELAY + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_CHECK   = 2'd2,
        ST_LATCHED = 2'd3
    } state_t;

    logic [BUS_W-1:0]  r_main_pipe [DCLS_DELAY+1];
    logic [BUS_W-1:0]  r_sec_d;
    state_t            r_state;
    logic [3:0]        r_arm_cnt;
    logic              r_error;
    logic [NUM_CH-1:0] r_err_vec;
    logic [NUM_CH-1:0] r_first_vec;
    logic              r_irq;
    logic [CNT_W-1:0]  r_count;

    logic [NUM_CH-1:0] w_mis;
    logic              w_any_mis;
    logic              w_active;

    // Pipelines free-run in every state so the comparison is aligned the moment CHECK begins.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i <= DCLS_DELAY; i++) begin
                r_main_pipe[i] <= '0;
            end
            r_sec_d <= '0;
        end else begin
            r_main_pipe[0] <= main_bus_i;
            for (int i = 1; i <= DCLS_DELAY; i++) begin
                r_main_pipe[i] <= r_main_pipe[i-1];
            end
            r_sec_d <= sec_bus_i;
        end
    end

    always_comb begin
        w_mis = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_mis[c] = (|(r_main_pipe[DCLS_DELAY][c*CH_W +: CH_W] ^ r_sec_d[c*CH_W +: CH_W]))
                       & ~ch_mask_i[c];
        end
    end

    assign w_any_mis = |w_mis;
    assign w_active  = enable_i && ((r_state == ST_CHECK) || (r_state == ST_LATCHED));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_arm_cnt   <= '0;
            r_error     <= 1'b0;
            r_err_vec   <= '0;
            r_first_vec <= '0;
            r_irq       <= 1'b0;
        end else begin
            r_irq <= 1'b0;
            if (!enable_i) begin
                r_state   <= ST_IDLE;
                r_arm_cnt <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state   <= ST_ARM;
                        r_arm_cnt <= '0;
                    end
                    ST_ARM: begin
                        if (r_arm_cnt == ARM_LAST) begin
                            r_state <= ST_CHECK;
                        end else begin
                            r_arm_cnt <= r_arm_cnt + 4'd1;
                        end
                    end
                    ST_CHECK: begin
                        if (w_any_mis) begin
                            r_state     <= ST_LATCHED;
                            r_first_vec <= w_mis;
                            r_err_vec   <= w_mis;
                            r_error     <= 1'b1;
                            r_irq       <= 1'b1;
                        end
                    end
                    ST_LATCHED: begin
                        // A fresh mismatch outranks a clear request and restarts the capture.
                        if (w_any_mis && clear_i) begin
                            r_first_vec <= w_mis;
                            r_err_vec   <= w_mis;
                            r_error     <= 1'b1;
                            r_irq       <= 1'b1;
                        end else if (clear_i) begin
                            r_state     <= ST_CHECK;
                            r_first_vec <= '0;
                            r_err_vec   <= '0;
                            r_error     <= 1'b0;
                        end else begin
                            r_err_vec <= r_err_vec | w_mis;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else if (w_active && w_any_mis) begin
            if (cnt_clr_i) begin
                r_count <= {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (r_count != CNT_MAX) begin
                r_count <= r_count + 1'b1;
            end
        end else if (cnt_clr_i) begin
            r_count <= '0;
        end
    end

    assign error_o        = r_error;
    assign error_vector_o = r_err_vec;
    assign first_vector_o = r_first_vec;
    assign irq_o          = r_irq;
    assign err_count_o    = r_count;
    assign state_o        = r_state;

endmodule

// File: tb/tb_dcls_lockstep_checker.sv
// tb/tb_dcls_lockstep_checker.sv - directed plus random lockstep checks against a queue-based model
module tb_dcls_lockstep_checker;

    localparam int NCH = 16;
    localparam int CW  = 32;
    localparam int D   = 2;
    localparam int CNW = 4;
    localparam int BW  = NCH * CW;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [BW-1:0]   main_bus_i;
    logic [BW-1:0]   sec_bus_i;
    logic [NCH-1:0]  ch_mask_i;
    logic            enable_i;
    logic            clear_i;
    logic            cnt_clr_i;
    logic            error_o;
    logic [NCH-1:0]  error_vector_o;
    logic [NCH-1:0]  first_vector_o;
    logic            irq_o;
    logic [CNW-1:0]  err_count_o;
    logic [1:0]      state_o;

    always #5 clk_i = ~clk_i;

    dcls_lockstep_checker #(
        .NUM_CH(NCH), .CH_W(CW), .DCLS_DELAY(D), .CNT_W(CNW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .main_bus_i(main_bus_i), .sec_bus_i(sec_bus_i),
        .ch_mask_i(ch_mask_i), .enable_i(enable_i),
        .clear_i(clear_i), .cnt_clr_i(cnt_clr_i),
        .error_o(error_o), .error_vector_o(error_vector_o),
        .first_vector_o(first_vector_o), .irq_o(irq_o),
        .err_count_o(err_count_o), .state_o(state_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: aligned sample history plus the abstract checker state.
    int             m_state;
    int             m_arm_cycles;
    logic           m_err;
    logic           m_irq;
    logic [NCH-1:0] m_ev;
    logic [NCH-1:0] m_fv;
    int             m_cnt;
    logic [BW-1:0]  m_mainq[$];
    logic [BW-1:0]  m_sec_seen;

    logic [BW-1:0]  hist[$];
    logic [BW-1:0]  corr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_arm_cycles = 0;
        m_err = 1'b0; m_irq = 1'b0; m_ev = '0; m_fv = '0; m_cnt = 0;
        m_mainq.delete();
        for (int i = 0; i <= D; i++) m_mainq.push_back('0);
        m_sec_seen = '0;
    endtask

    task automatic model_edge();
        logic [BW-1:0]  oldest;
        logic [NCH-1:0] mis;
        bit             counting;
        oldest = m_mainq[0];
        for (int c = 0; c < NCH; c++)
            mis[c] = (oldest[c*CW +: CW] != m_sec_seen[c*CW +: CW]) && !ch_mask_i[c];
        counting = enable_i && (m_state >= 2) && (mis != 0);
        if (counting) m_cnt = cnt_clr_i ? 1 : ((m_cnt < 15) ? m_cnt + 1 : 15);
        else if (cnt_clr_i) m_cnt = 0;
        m_irq = 1'b0;
        if (!enable_i) begin
            m_state = 0;
        end else if (m_state == 0) begin
            m_state = 1; m_arm_cycles = 0;
        end else if (m_state == 1) begin
            m_arm_cycles++;
            if (m_arm_cycles == D + 2) m_state = 2;
        end else if (m_state == 2) begin
            if (mis != 0) begin
                m_state = 3; m_ev = mis; m_fv = mis; m_err = 1'b1; m_irq = 1'b1;
            end
        end else begin
            if (mis != 0 && clear_i) begin
                m_ev = mis; m_fv = mis; m_err = 1'b1; m_irq = 1'b1;
            end else if (clear_i) begin
                m_state = 2; m_ev = '0; m_fv = '0; m_err = 1'b0;
            end else begin
                m_ev = m_ev | mis;
            end
        end
        m_mainq.push_back(main_bus_i);
        void'(m_mainq.pop_front());
        m_sec_seen = sec_bus_i;
    endtask

    task automatic check_all();
        chk("state", 64'(state_o), 64'(m_state));
        chk("error", 64'(error_o), 64'(m_err));
        chk("irq", 64'(irq_o), 64'(m_irq));
        chk("err_vec", 64'(error_vector_o), 64'(m_ev));
        chk("first_vec", 64'(first_vector_o), 64'(m_fv));
        chk("count", 64'(err_count_o), 64'(m_cnt));
    endtask

    task automatic drive_stream();
        logic [BW-1:0] m;
        for (int w = 0; w < NCH; w++) m[w*CW +: CW] = $urandom;
        hist.push_back(m);
        if (hist.size() > D + 1) void'(hist.pop_front());
        main_bus_i = m;
        sec_bus_i  = hist[0] ^ corr;
    endtask

    task automatic cyc();
        drive_stream();
        @(posedge clk_i);
        if (rst_i) model_reset();
        else model_edge();
        @(negedge clk_i);
        check_all();
    endtask

    task automatic corrupt_bit(input int ch, input int bitpos);
        corr = '0;
        corr[ch*CW + bitpos] = 1'b1;
    endtask

    initial begin
        rst_i = 1'b1; enable_i = 1'b0; clear_i = 1'b0; cnt_clr_i = 1'b0;
        ch_mask_i = '0; corr = '0; main_bus_i = '0; sec_bus_i = '0;
        for (int i = 0; i < D; i++) hist.push_back('0);
        model_reset();
        repeat (2) cyc();
        chk("reset_state", 64'(state_o), 64'd0);

        rst_i = 1'b0; enable_i = 1'b1;
        repeat (5) cyc();
        chk("arm_to_check", 64'(state_o), 64'd2);
        repeat (10) cyc();
        chk("clean_stream_error", 64'(error_o), 64'd0);

        corrupt_bit(3, 5); cyc(); corr = '0; cyc();
        chk("first_err_latency", 64'(error_o), 64'd1);
        chk("first_irq", 64'(irq_o), 64'd1);
        chk("ch3_first_vec", 64'(first_vector_o), 64'h0008);
        chk("ch3_count", 64'(err_count_o), 64'd1);
        cyc();
        chk("irq_one_cycle", 64'(irq_o), 64'd0);

        clear_i = 1'b1; cnt_clr_i = 1'b1; cyc(); clear_i = 1'b0; cnt_clr_i = 1'b0;
        repeat (2) cyc();
        corrupt_bit(3, 0); cyc(); corr = '0; repeat (2) cyc();
        corrupt_bit(7, 9); cyc(); corr = '0; repeat (3) cyc();
        chk("accum_err_vec", 64'(error_vector_o), 64'h0088);
        chk("accum_first_vec", 64'(first_vector_o), 64'h0008);
        chk("accum_count", 64'(err_count_o), 64'd2);
        clear_i = 1'b1; cyc(); clear_i = 1'b0;
        chk("clear_state", 64'(state_o), 64'd2);
        chk("clear_vec", 64'(error_vector_o), 64'd0);

        ch_mask_i[3] = 1'b1; corrupt_bit(3, 17);
        repeat (10) cyc();
        chk("masked_error", 64'(error_o), 64'd0);
        chk("masked_count", 64'(err_count_o), 64'd2);
        ch_mask_i[3] = 1'b0; cyc(); corr = '0;
        chk("unmask_flags", 64'(first_vector_o), 64'h0008);
        repeat (2) cyc();

        cnt_clr_i = 1'b1; cyc(); cnt_clr_i = 1'b0;
        corrupt_bit(0, 31);
        repeat (20) cyc();
        chk("count_saturate", 64'(err_count_o), 64'd15);
        cnt_clr_i = 1'b1; cyc(); cnt_clr_i = 1'b0;
        chk("cnt_clr_with_mis", 64'(err_count_o), 64'd1);
        corr = '0; repeat (3) cyc();

        corrupt_bit(1, 2); cyc(); corr = '0; clear_i = 1'b1; cyc(); clear_i = 1'b0;
        chk("clear_vs_mis_state", 64'(state_o), 64'd3);
        chk("clear_vs_mis_first", 64'(first_vector_o), 64'h0002);
        chk("clear_vs_mis_irq", 64'(irq_o), 64'd1);

        enable_i = 1'b0; cyc();
        chk("disable_idle", 64'(state_o), 64'd0);
        chk("disable_keeps_err", 64'(error_o), 64'd1);
        enable_i = 1'b1; cyc();
        chk("reenable_arm", 64'(state_o), 64'd1);
        repeat (6) cyc();

        for (int n = 0; n < 400; n++) begin
            corr = '0;
            if ($urandom_range(0, 7) == 0) corrupt_bit($urandom_range(0, NCH-1), $urandom_range(0, CW-1));
            ch_mask_i = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '0;
            clear_i   = ($urandom_range(0, 5) == 0);
            cnt_clr_i = ($urandom_range(0, 15) == 0);
            enable_i  = ($urandom_range(0, 59) != 0);
            cyc();
        end
        corr = '0; ch_mask_i = '0; clear_i = 1'b0; cnt_clr_i = 1'b0; enable_i = 1'b1;
        repeat (6) cyc();
        if (state_o == 2'd2) begin
            corrupt_bit(5, 4); cyc(); corr = '0; cyc();
        end else begin
            repeat (2) cyc();
        end
        chk("pre_reset_latched", 64'(state_o), 64'd3);

        #2 rst_i = 1'b1;
        #1 model_reset();
        check_all();
        chk("async_reset_error", 64'(error_o), 64'd0);
        @(negedge clk_i);
        cyc();
        rst_i = 1'b0;
        cyc();
        chk("post_reset_arm", 64'(state_o), 64'd1);
        repeat (6) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dcls_lockstep_checker.md
DCLS_LOCKSTEP_CHECKER -- requirements
Module: dcls_lockstep_checker

Interface
REQ-001 SHALL have parameter NUM_CH, default 16, range 1..32: number of independently compared channels.
REQ-002 SHALL have parameter CH_W, default 32, range 1..64: bit width of each channel.
REQ-003 SHALL have parameter DCLS_DELAY, default 2, range 1..8: cycles by which the secondary core lags the main core.
REQ-004 SHALL have parameter CNT_W, default 16: mismatch counter width.
REQ-005 clk_i  in  1  single clock; all logic on its rising edge.
REQ-006 rst_i  in  1  reset, asynchronous, active-high.
REQ-007 main_bus_i  in  NUM_CH*CH_W  main-core outputs; channel c occupies bits [c*CH_W +: CH_W].
REQ-008 sec_bus_i  in  NUM_CH*CH_W  secondary-core outputs, same packing as main_bus_i.
REQ-009 ch_mask_i  in  NUM_CH  1 = channel c excluded from comparison.
REQ-010 enable_i  in  1  checking enable.
REQ-011 clear_i  in  1  single-cycle request to clear sticky error state.
REQ-012 cnt_clr_i  in  1  single-cycle request to zero the mismatch counter.
REQ-013 error_o  out  1  sticky: any unmasked mismatch since the last clear.
REQ-014 error_vector_o  out  NUM_CH  sticky per-channel mismatch flags.
REQ-015 first_vector_o  out  NUM_CH  mismatch vector of the first failing cycle.
REQ-016 irq_o  out  1  one-cycle pulse on the CHECK->LATCHED transition.
REQ-017 err_count_o  out  CNT_W  saturating count of mismatching cycles.
REQ-018 state_o  out  2  encoded FSM state: IDLE=0, ARM=1, CHECK=2, LATCHED=3.

Function
REQ-019 Main path SHALL delay main_bus_i by DCLS_DELAY+1 register stages; secondary path SHALL delay sec_bus_i by 1 stage.
- Net effect: main sample from cycle t is compared with secondary sample from cycle t+DCLS_DELAY.
REQ-020 Per-channel mismatch SHALL be mis[c] = OR-reduce(main_d[c] XOR sec_d[c]) AND NOT ch_mask_i[c], with ch_mask_i taken combinationally at the compare stage.
REQ-021 All outputs SHALL be registered; the first mismatch appears on error_o exactly 2 cycles after the offending sec_bus_i sample.
REQ-022 FSM: IDLE->ARM when enable_i=1; ARM->CHECK after DCLS_DELAY+2 cycles in ARM; CHECK->LATCHED on any mis=1; any state->IDLE when enable_i=0.
REQ-023 In IDLE and ARM, mismatches SHALL be ignored: no sticky update, no count, no irq.
REQ-024 On CHECK->LATCHED:
- first_vector_o <= mis
- error_vector_o <= mis
- error_o <= 1
- irq_o pulses high for exactly 1 cycle.
REQ-025 In LATCHED, error_vector_o SHALL accumulate OR of mis each cycle; first_vector_o SHALL hold its value.
REQ-026 clear_i in LATCHED:
- error_o, error_vector_o, first_vector_o <= 0
- next state CHECK (no re-arm).
- clear_i in any other state SHALL have no effect.
REQ-027 clear_i in the same cycle as mis!=0 in LATCHED: the new mismatch wins; state stays LATCHED, vectors <= mis, first_vector_o <= mis, irq_o pulses.
REQ-028 err_count_o SHALL increment by 1 per cycle with mis!=0 in CHECK or LATCHED, and SHALL saturate at 2^CNT_W-1 without wrap.
REQ-029 cnt_clr_i SHALL zero the counter; cnt_clr_i together with a counted mismatch SHALL load 1.
REQ-030 Delay pipelines SHALL keep shifting in all states, so the comparison is valid immediately on entry to CHECK.
REQ-031 enable_i dropping in LATCHED SHALL keep sticky outputs and count until clear_i or reset; re-enable re-arms through ARM.

Reset
REQ-032 rst_i=1 SHALL asynchronously force:
- all pipeline stages, error_o, error_vector_o, first_vector_o, irq_o, err_count_o <= 0
- state <= IDLE.
REQ-033 After rst_i release with enable_i=1, the FSM SHALL pass through ARM; reset mid-LATCHED SHALL lose all captured state.

Verification
REQ-034 DCLS_DELAY=2, identical streams with sec lagging by 2, enable_i=1 -> state_o reaches 2 after 1+4 cycles; error_o stays 0; err_count_o=0.
REQ-035 Flip bit 5 of channel 3 on sec_bus_i for 1 cycle -> error_o=1 and irq_o pulse 2 cycles later; error_vector_o=first_vector_o=0x0008; err_count_o=1.
REQ-036 Mismatch on channel 3, then channel 7 three cycles later -> error_vector_o=0x0088, first_vector_o=0x0008, err_count_o=2; clear_i -> all 0, state_o=2.
REQ-037 ch_mask_i[3]=1 with channel 3 corrupted for 10 cycles -> no error, count 0; unmasking mid-run flags the next mismatching cycle.
REQ-038 CNT_W=4 with continuous mismatch for 20 cycles -> err_count_o holds 15; cnt_clr_i with a concurrent mismatch -> 1.
REQ-039 rst_i asserted asynchronously between edges while in LATCHED -> all outputs 0 immediately, state_o=0.
